gcd_param_unit: RTL and testbench
=================================

GCD_PARAM_UNIT -- requirements
Module: gcd_param_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width in bits (legal 2..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  advance enable; low = full stall.
REQ-005 SHALL have port start  input  1  request to begin a computation.
REQ-006 SHALL have port x_i  input  WIDTH  operand X, sampled on the accept edge only.
REQ-007 SHALL have port y_i  input  WIDTH  operand Y, sampled on the accept edge only.
REQ-008 SHALL have port busy  output  1  high from the accept edge until return to IDLE.
REQ-009 SHALL have port done  output  1  result-valid, one cycle per computation when enable is held high.
REQ-010 SHALL have port d_o  output  WIDTH  GCD result, held until the next accept edge.

Function
REQ-011 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-012 SHALL accept a request on a rising edge where state=IDLE, start=1 and enable=1: load X<=x_i, Y<=y_i and go to CALC.
REQ-013 SHALL ignore start while busy=1.
REQ-014 SHALL evaluate the following on each enabled CALC edge, in priority order:
- X=0 -> d_o<=Y, go to DONE;
- Y=0 -> d_o<=X, go to DONE;
- X=Y -> d_o<=X, go to DONE;
- X>Y -> X<=X-Y;
- X<Y -> Y<=Y-X.
REQ-015 SHALL use an unsigned comparator and subtractor, both WIDTH bits; subtraction never underflows given REQ-014 ordering.
REQ-016 SHALL, for a computation needing k subtractions, assert done in the cycle after the (k+1)th enabled edge following the accept edge.
REQ-017 SHALL go from DONE to IDLE on the next enabled edge, deasserting done and busy.
REQ-018 SHALL allow back-to-back operation: start may be accepted on the edge immediately after the return to IDLE.
REQ-019 SHALL, while enable=0, hold state, X, Y, d_o, done and busy unchanged; a DONE-state done stays high until the next enabled edge.
REQ-020 SHALL return gcd(0,0)=0 and gcd(a,0)=gcd(0,a)=a with k=0.

Reset
REQ-021 SHALL, on any edge with reset=1, force state=IDLE, X=0, Y=0, d_o=0, done=0 and busy=0, regardless of enable or start.
REQ-022 SHALL abort any computation in progress when reset is asserted mid-operation, with no done pulse.
REQ-023 SHALL give reset priority over a start accept on the same edge.

Configuration
REQ-024 SHALL, when macro GCD_ITER_COUNT_EN is defined, add output port iter_count  output  WIDTH  number of subtractions in the current/last computation.
REQ-025 iter_count SHALL clear on accept and on reset, increment on each subtracting CALC edge, saturate at all-ones, and hold with d_o.
REQ-026 SHALL omit the iter_count port and counter logic entirely when GCD_ITER_COUNT_EN is undefined; all other behaviour is identical.

Structure
REQ-027 SHALL place the FSM state encoding (IDLE/CALC/DONE) and the default WIDTH constant in shared package gcd_pkg.
REQ-028 SHALL split into the top level (FSM and handshake) and one sub-module gcd_datapath, which holds the X/Y/d_o registers, comparator and subtractor and provides x_neq_y and x_lt_y status to the FSM.

Verification
REQ-029 Basic: WIDTH=4, x_i=12, y_i=8, start with enable=1 -> done high in the cycle after the 3rd edge past accept, d_o=4, iter_count=2.
REQ-030 Zero operands: (0,9) -> d_o=9, k=0. (7,0) -> d_o=7. (0,0) -> d_o=0. Each gives done after the 1st edge past accept.
REQ-031 Stall and busy: (15,1) with enable low for 3 cycles mid-CALC -> X/Y frozen during the stall, final d_o=1, iter_count=14, done extended by the stall. A start pulse while busy is ignored.
REQ-032 Reset: reset on the 2nd CALC edge of (12,8) -> next cycle busy=0, done=0, d_o=0. A new request (9,6) then yields d_o=3.
REQ-033 Wide and back-to-back: WIDTH=16, (65535,1) -> d_o=1, iter_count=65534. An immediate next start (48,18) is accepted on the first IDLE edge and yields d_o=6.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared constants and FSM encoding for the subtractive GCD unit.
// Optional iteration counter is enabled by defining GCD_ITER_COUNT_EN.
package gcd_pkg;

    localparam int GCD_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gcd_state_t;

endpackage

// File: rtl/gcd_datapath.sv
// X/Y/result registers with one shared comparator and subtractor for the GCD unit.
// Defining GCD_ITER_COUNT_EN adds a saturating subtraction counter.
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             sub,
    input  logic             capture,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic             x_neq_y,
    output logic             x_lt_y,
    output logic             x_zero,
    output logic             y_zero,
    output logic [WIDTH-1:0] d_o
`ifdef GCD_ITER_COUNT_EN
    ,
    output logic [WIDTH-1:0] iter_count
`endif
);

    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] sub_a;
    logic [WIDTH-1:0] sub_b;
    logic [WIDTH-1:0] diff;

    always_comb begin
        x_zero  = (x_q == '0);
        y_zero  = (y_q == '0);
        x_neq_y = (x_q != y_q);
        x_lt_y  = (x_q < y_q);
        // Larger minus smaller, so the single subtractor can never underflow.
        sub_a   = x_lt_y ? y_q : x_q;
        sub_b   = x_lt_y ? x_q : y_q;
        diff    = sub_a - sub_b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
            d_q <= '0;
        end else if (load) begin
            x_q <= x_i;
            y_q <= y_i;
        end else if (capture) begin
            d_q <= x_zero ? y_q : x_q;
        end else if (sub) begin
            if (x_lt_y) begin
                y_q <= diff;
            end else begin
                x_q <= diff;
            end
        end
    end

    assign d_o = d_q;

`ifdef GCD_ITER_COUNT_EN
    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            cnt_q <= '0;
        end else if (sub && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign iter_count = cnt_q;
`endif

endmodule

// File: rtl/gcd_param_unit.sv
// Subtractive GCD unit: FSM and start/busy/done handshake around gcd_datapath.
// Defining GCD_ITER_COUNT_EN exposes the iter_count output.
//
// state | meaning
// IDLE  | waiting for start with enable high
// CALC  | one compare/subtract step per enabled edge
// DONE  | d_o valid, done high until the next enabled edge
module gcd_param_unit
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d_o
`ifdef GCD_ITER_COUNT_EN
    ,
    output logic [WIDTH-1:0] iter_count
`endif
);

    gcd_state_t state_q;
    gcd_state_t state_d;

    logic load;
    logic sub;
    logic capture;
    logic finish;
    logic x_neq_y;
    logic x_lt_y;
    logic x_zero;
    logic y_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        sub     = 1'b0;
        capture = 1'b0;
        // Zero operands and equality all terminate; otherwise keep subtracting.
        finish  = x_zero || y_zero || !x_neq_y;
        case (state_q)
            IDLE: begin
                if (enable && start) begin
                    load    = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (enable) begin
                    if (finish) begin
                        capture = 1'b1;
                        state_d = DONE;
                    end else begin
                        sub = 1'b1;
                    end
                end
            end
            DONE: begin
                if (enable) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    gcd_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .sub       (sub),
        .capture   (capture),
        .x_i       (x_i),
        .y_i       (y_i),
        .x_neq_y   (x_neq_y),
        .x_lt_y    (x_lt_y),
        .x_zero    (x_zero),
        .y_zero    (y_zero),
        .d_o       (d_o)
`ifdef GCD_ITER_COUNT_EN
        ,
        .iter_count(iter_count)
`endif
    );

endmodule

// File: tb/tb_gcd_param_unit.sv
// Self-checking bench: a WIDTH=4 and a WIDTH=16 instance share stimulus and are
// checked against a Euclid-based reference model; GCD_ITER_COUNT_EN adds counter checks.
module tb_gcd_param_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        start;
    logic [15:0] x;
    logic [15:0] y;

    logic        busy4, done4, busy16, done16;
    logic [3:0]  d4;
    logic [15:0] d16;
`ifdef GCD_ITER_COUNT_EN
    logic [3:0]  iter4;
    logic [15:0] iter16;
`endif

    int vectors = 0;
    int errors  = 0;
    int unsigned cur_x, cur_y;

    always #5 clk = ~clk;

    gcd_param_unit #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .start     (start),
        .x_i       (x[3:0]),
        .y_i       (y[3:0]),
        .busy      (busy4),
        .done      (done4),
        .d_o       (d4)
`ifdef GCD_ITER_COUNT_EN
        ,
        .iter_count(iter4)
`endif
    );

    gcd_param_unit #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .start     (start),
        .x_i       (x),
        .y_i       (y),
        .busy      (busy16),
        .done      (done16),
        .d_o       (d16)
`ifdef GCD_ITER_COUNT_EN
        ,
        .iter_count(iter16)
`endif
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: Euclid with division; each quotient counts as that many subtractions,
    // except an exact division stops one short because X==Y terminates.
    function automatic void gcd_ref(input int unsigned a_in, input int unsigned b_in,
                                    output int unsigned g, output int unsigned k);
        int unsigned a, b, q, r;
        a = a_in;
        b = b_in;
        k = 0;
        while (a != 0 && b != 0 && a != b) begin
            if (a > b) begin
                q = a / b;
                r = a % b;
                if (r == 0) begin
                    k += q - 1;
                    a = b;
                end else begin
                    k += q;
                    a = r;
                end
            end else begin
                q = b / a;
                r = b % a;
                if (r == 0) begin
                    k += q - 1;
                    b = a;
                end else begin
                    k += q;
                    b = r;
                end
            end
        end
        g = (a == 0) ? b : a;
    endfunction

    task automatic wait_done(input int stall_at, input int stall_len,
                             input bit poke_start, input bit hold_done);
        int unsigned g4, k4, g16, k16;
        int edges, total, lat4, lat16;
        logic [31:0] cap_d4, cap_d16, cap_it4, cap_it16;
        gcd_ref(cur_x & 32'hF, cur_y & 32'hF, g4, k4);
        gcd_ref(cur_x, cur_y, g16, k16);
        edges = 0;
        total = 0;
        lat4  = -1;
        lat16 = -1;
        cap_d4 = '0; cap_d16 = '0; cap_it4 = '0; cap_it16 = '0;
        while ((lat4 < 0 || lat16 < 0) && edges < 70000) begin
            if (edges == stall_at) begin
`ifdef GCD_ITER_COUNT_EN
                cap_it16 = 32'(iter16);
`endif
                enable = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    total++;
                    check("stall_busy", 32'(busy16), 32'd1);
                    check("stall_done", 32'(done16), 32'd0);
`ifdef GCD_ITER_COUNT_EN
                    check("stall_iter_frozen", 32'(iter16), cap_it16);
`endif
                end
                enable = 1'b1;
            end
            if (poke_start && edges == 2) begin
                x = 16'd3;
                y = 16'd3;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            edges++;
            total++;
            if (lat4 < 0 && done4) begin
                lat4 = edges;
                cap_d4 = 32'(d4);
`ifdef GCD_ITER_COUNT_EN
                cap_it4 = 32'(iter4);
`endif
            end
            if (lat16 < 0 && done16) begin
                lat16 = edges;
                cap_d16 = 32'(d16);
`ifdef GCD_ITER_COUNT_EN
                cap_it16 = 32'(iter16);
`endif
            end
        end
        check("latency_w16", 32'(lat16), 32'(k16 + 1));
        check("result_w16", cap_d16, g16);
        check("latency_w4", 32'(lat4), 32'(k4 + 1));
        check("result_w4", cap_d4, g4);
`ifdef GCD_ITER_COUNT_EN
        check("iter_w16", cap_it16, k16);
        check("iter_w4", cap_it4, k4);
`endif
        if (stall_at >= 0) begin
            check("stalled_total", 32'(total), 32'(k16 + 1 + stall_len));
        end
        if (hold_done) begin
            enable = 1'b0;
            tick();
            tick();
            check("done_held", 32'(done16), 32'd1);
            check("d_held", 32'(d16), g16);
            enable = 1'b1;
        end
        tick();
        check("idle_busy_w16", 32'(busy16), 32'd0);
        check("idle_done_w16", 32'(done16), 32'd0);
        check("idle_busy_w4", 32'(busy4), 32'd0);
        check("idle_done_w4", 32'(done4), 32'd0);
        check("d_after_idle", 32'(d16), g16);
    endtask

    task automatic run_op(input int unsigned a, input int unsigned b, input int stall_at,
                          input int stall_len, input bit poke_start, input bit hold_done);
        cur_x  = a;
        cur_y  = b;
        x      = a[15:0];
        y      = b[15:0];
        start  = 1'b1;
        enable = 1'b1;
        tick();
        start = 1'b0;
        check("accept_busy_w16", 32'(busy16), 32'd1);
        check("accept_busy_w4", 32'(busy4), 32'd1);
        check("accept_done_w16", 32'(done16), 32'd0);
        wait_done(stall_at, stall_len, poke_start, hold_done);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        start  = 1'b1;
        x      = 16'd5;
        y      = 16'd3;
        @(negedge clk);
        tick();
        tick();
        check("rst_busy", 32'(busy16), 32'd0);
        check("rst_done", 32'(done16), 32'd0);
        check("rst_d", 32'(d16), 32'd0);
        check("rst_busy_w4", 32'(busy4), 32'd0);
        start = 1'b0;
        reset = 1'b0;
        tick();
        check("idle_no_start", 32'(busy16), 32'd0);

        run_op(12, 8, -1, 0, 1'b0, 1'b0);
        run_op(0, 9, -1, 0, 1'b0, 1'b0);
        run_op(7, 0, -1, 0, 1'b0, 1'b0);
        run_op(0, 0, -1, 0, 1'b0, 1'b0);
        run_op(15, 1, 5, 3, 1'b1, 1'b1);

        x = 16'd12;
        y = 16'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 32'(busy16), 32'd0);
        check("abort_done", 32'(done16), 32'd0);
        check("abort_d", 32'(d16), 32'd0);
        tick();
        check("abort_no_done", 32'(done16), 32'd0);
        run_op(9, 6, -1, 0, 1'b0, 1'b0);

        run_op(65535, 1, -1, 0, 1'b0, 1'b0);
        run_op(48, 18, -1, 0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            int unsigned ra, rb;
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            if ($urandom_range(0, 7) == 0) ra = 0;
            if ($urandom_range(0, 7) == 0) rb = 0;
            run_op(ra, rb, -1, 0, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
